amstrad_int_gen: RTL and testbench
==================================

// Module: amstrad_int_gen
// PURPOSE
//  Parametrised successor of the gate-array interrupt generator. Divides CRTC HSYNC into periodic
//  interrupts (default /52, VSYNC-resynchronised after VS_DELAY lines) and adds NUM_RASTER
//  programmable raster-line interrupt channels with a source-id output. Sits beside the gate
//  array: CRTC sync in, Z80 INT/ack out.
// PARAMETERS
//  LINE_DIV    52  periodic divider; counter wraps at LINE_DIV-1 and raises source 0
//  VS_DELAY    2   HSYNC falling edges after VSYNC rise before the resync check
//  CNT_W       6   line-counter width; MSB (CNT_W-1) is the ack-guard bit; LINE_DIV <= 2**CNT_W
//  NUM_RASTER  3   raster compare channels (sources 1..NUM_RASTER), 0..7
//  LINE_W      9   scanline counter / compare width
// PORTS
//  CLK         in   1       system clock
//  RESET_n     in   1       asynchronous active-low reset
//  CE_4        in   1       4 MHz clock enable
//  SAMPLE      in   1       sync-sample strobe, 1 per us; acts only when CE_4=1
//  crtc_hs     in   1       CRTC HSYNC
//  crtc_vs     in   1       CRTC VSYNC
//  INTack      in   1       Z80 interrupt acknowledge, 1-CLK pulse
//  WE          in   1       gate-array register write strobe
//  D           in   8       gate-array write data
//  RAS_WE      in   1       raster channel register write
//  RAS_SEL     in   3       channel index for RAS_WE (>= NUM_RASTER ignored)
//  RAS_LINE    in   LINE_W  compare scanline
//  RAS_EN      in   1       channel enable
//  INT         out  1       interrupt request (OR of pending)
//  INT_SRC     out  3       lowest-index pending source; 0 when none
//  LINE_CNT    out  CNT_W   periodic line counter
//  VLINE       out  LINE_W  scanline counter since last VSYNC rise
// BEHAVIOUR
//  - Reset (async, RESET_n=0): INT=0, INT_SRC=0, LINE_CNT=0, VLINE=0, pending=0, delay=0,
//    raster channels disabled with line 0, sync history regs 0. Reset mid-frame discards all state.
//  - Tick = CE_4 & SAMPLE. Each tick samples crtc_hs/crtc_vs into old_hs/old_vs; edges are
//    old vs new sample. Outputs update on the CLK edge of the event (0-cycle latency vs tick).
//  - HSYNC fall: LINE_CNT+1; VLINE+1 (saturates at all-ones). At LINE_CNT==LINE_DIV-1:
//    LINE_CNT<=0, pending[0]<=1.
//  - VSYNC rise: delay<=VS_DELAY, VLINE<=0 (wins over an HSYNC-fall VLINE increment).
//  - delay!=0 on HSYNC fall: delay-1; reaching 0: pending[0]<=1 if LINE_CNT[CNT_W-1] set
//    (pre-increment value); LINE_CNT<=0 (overrides the increment/wrap; no double raise).
//  - Raster: on HSYNC fall, channel i with en[i] & line[i]==VLINE (post-update) sets
//    pending[i+1]. RAS_WE writes line/en in 1 CLK, effective from the next HSYNC fall.
//  - INT=|pending. INT_SRC=lowest set index; combinational from registered pending.
//  - INTack: clears pending[INT_SRC] (INT_SRC at ack cycle); if INT_SRC==0 also clears
//    LINE_CNT[CNT_W-1]. Ack with INT=0: no effect.
//  - WE & D[7:6]==2'b10 & D[4]: LINE_CNT<=0, pending[0]<=0, delay unchanged.
//  - Same-cycle priority, highest first: reset > WE counter clear > delay-zero resync >
//    HSYNC increment/wrap; ack MSB-clear applies to the value after increment. A pending set
//    and an ack/clear of the same bit in one cycle: set wins (event never lost).
//  - Widths: all counters modulo 2**width except VLINE (saturating) and delay (stops at 0).
// STRUCTURE
//  - Package amstrad_pkg: SRC_W=3, GA_CMD_RMR=2'b10, RMR_INT_CLR_BIT=4, default localparams.
//  - Sub-module amstrad_raster_cmp (one per channel, generate loop): line/en regs, RAS_WE
//    decode, compare -> hit. Periodic counter, delay, priority encoder stay in the top.
// TESTING
//  1 Free-run HS, no VS: INT rises on the 52nd HS fall, INT_SRC=0, LINE_CNT=0; ack -> INT=0.
//  2 VS rise at LINE_CNT=40: 2nd HS fall after it raises INT, LINE_CNT=0; VS at LINE_CNT=20
//    -> no INT, LINE_CNT=0.
//  3 INT at count 52, ack delayed to LINE_CNT=35: LINE_CNT becomes 3; next INT 49 lines later.
//  4 Channel 1 line=100 en=1, VS then 100 HS falls: INT_SRC=2 on the 100th; periodic pending
//    too -> INT_SRC=0 first, ack -> INT_SRC=2, ack -> INT=0.
//  5 WE D=8'h90 same cycle as HS fall at LINE_CNT=51: LINE_CNT=0, pending[0]=0, INT=0.
//  6 RESET_n low between CLK edges mid-frame: outputs 0 immediately; release -> first INT
//    after 52 HS falls; INTack with INT=0 changes nothing.

Source files
------------

// File: rtl/amstrad_pkg.sv
// Shared constants for the interrupt generator: gate-array command decode,
// source-id width and default parameter values.
package amstrad_pkg;

  localparam int SRC_W            = 3;
  localparam logic [1:0] GA_CMD_RMR = 2'b10;
  localparam int RMR_INT_CLR_BIT  = 4;

  localparam int LINE_DIV_DEF     = 52;
  localparam int VS_DELAY_DEF     = 2;
  localparam int CNT_W_DEF        = 6;
  localparam int NUM_RASTER_DEF   = 3;
  localparam int LINE_W_DEF       = 9;

  // Width needed to hold the VSYNC delay reload value (at least one bit).
  function automatic int dly_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/amstrad_int_gen_if.sv
// Sync/ack/register bus between the system side and the interrupt generator.
interface amstrad_int_gen_if
  import amstrad_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) ();

  logic              CE_4;
  logic              SAMPLE;
  logic              crtc_hs;
  logic              crtc_vs;
  logic              INTack;
  logic              WE;
  logic [7:0]        D;
  logic              RAS_WE;
  logic [SRC_W-1:0]  RAS_SEL;
  logic [LINE_W-1:0] RAS_LINE;
  logic              RAS_EN;
  logic              INT;
  logic [SRC_W-1:0]  INT_SRC;
  logic [CNT_W-1:0]  LINE_CNT;
  logic [LINE_W-1:0] VLINE;

  modport master (
    output CE_4, SAMPLE, crtc_hs, crtc_vs, INTack, WE, D,
           RAS_WE, RAS_SEL, RAS_LINE, RAS_EN,
    input  INT, INT_SRC, LINE_CNT, VLINE
  );

  modport slave (
    input  CE_4, SAMPLE, crtc_hs, crtc_vs, INTack, WE, D,
           RAS_WE, RAS_SEL, RAS_LINE, RAS_EN,
    output INT, INT_SRC, LINE_CNT, VLINE
  );

endinterface

// File: rtl/amstrad_raster_cmp.sv
// One raster-line interrupt channel: holds its compare line and enable, and
// flags a hit on the HSYNC fall whose updated scanline matches.
module amstrad_raster_cmp
  import amstrad_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int IDX    = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ras_we_i,
  input  logic [SRC_W-1:0]  ras_sel_i,
  input  logic [LINE_W-1:0] ras_line_i,
  input  logic              ras_en_i,
  input  logic              hs_fall_i,
  input  logic [LINE_W-1:0] vline_i,
  output logic              hit_o
);

  logic [LINE_W-1:0] line_q;
  logic              en_q;

  // Channel register write; the new value is only seen by later HSYNC falls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      line_q <= '0;
      en_q   <= 1'b0;
    end else if (ras_we_i && (ras_sel_i == SRC_W'(IDX))) begin
      line_q <= ras_line_i;
      en_q   <= ras_en_i;
    end
  end

  // vline_i is the post-update scanline of the current HSYNC fall.
  assign hit_o = hs_fall_i & en_q & (line_q == vline_i);

endmodule

// File: rtl/amstrad_int_gen.sv
// Gate-array style interrupt generator: HSYNC-divided periodic interrupt with
// VSYNC resync, plus programmable raster-line channels and a source id.
module amstrad_int_gen
  import amstrad_pkg::*;
#(
  parameter int LINE_DIV   = LINE_DIV_DEF,
  parameter int VS_DELAY   = VS_DELAY_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NUM_RASTER = NUM_RASTER_DEF,
  parameter int LINE_W     = LINE_W_DEF
) (
  input logic              CLK,
  input logic              RESET_n,
  amstrad_int_gen_if.slave bus
);

  localparam int PEND_W = NUM_RASTER + 1;
  localparam int DLY_W  = dly_width(VS_DELAY);
  localparam int MSB    = CNT_W - 1;

  logic              old_hs_q, old_vs_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] vline_q, vline_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [PEND_W-1:0] set_vec, clr_vec;
  logic [SRC_W-1:0]  src;
  logic              tick, hs_fall, vs_rise, we_clr, int_req, ack;
  logic              resync, set0;

  assign tick    = bus.CE_4 & bus.SAMPLE;
  assign hs_fall = tick & old_hs_q & ~bus.crtc_hs;
  assign vs_rise = tick & ~old_vs_q & bus.crtc_vs;
  assign we_clr  = bus.WE & (bus.D[7:6] == GA_CMD_RMR) & bus.D[RMR_INT_CLR_BIT];
  assign int_req = |pend_q;
  assign ack     = bus.INTack & int_req;

  // Lowest pending index wins the source id.
  always_comb begin
    src = '0;
    for (int i = PEND_W - 1; i >= 0; i--) begin
      if (pend_q[i]) src = SRC_W'(i);
    end
  end

  // Periodic divider, VSYNC resync delay and scanline counter.
  always_comb begin
    delay_d = delay_q;
    resync  = 1'b0;
    if (vs_rise) begin
      delay_d = DLY_W'(VS_DELAY);
    end else if (hs_fall && (delay_q != '0)) begin
      delay_d = delay_q - DLY_W'(1);
      resync  = (delay_q == DLY_W'(1));
    end

    cnt_d = cnt_q;
    set0  = 1'b0;
    if (we_clr) begin
      cnt_d = '0;
    end else if (resync) begin
      // Resync raises only if the counter is in its upper half, so an
      // interrupt that just fired is not repeated.
      cnt_d = '0;
      set0  = cnt_q[MSB];
    end else if (hs_fall) begin
      if (cnt_q == CNT_W'(LINE_DIV - 1)) begin
        cnt_d = '0;
        set0  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Acking the periodic source drops the guard bit of the updated count.
    if (ack && (src == '0)) cnt_d[MSB] = 1'b0;

    vline_d = vline_q;
    if (vs_rise) begin
      vline_d = '0;
    end else if (hs_fall && (vline_q != '1)) begin
      vline_d = vline_q + LINE_W'(1);
    end
  end

  assign set_vec[0] = set0;

  // One compare channel per raster source.
  for (genvar g = 0; g < NUM_RASTER; g++) begin : g_ras
    amstrad_raster_cmp #(
      .LINE_W (LINE_W),
      .IDX    (g)
    ) u_cmp (
      .clk_i      (CLK),
      .rst_n_i    (RESET_n),
      .ras_we_i   (bus.RAS_WE),
      .ras_sel_i  (bus.RAS_SEL),
      .ras_line_i (bus.RAS_LINE),
      .ras_en_i   (bus.RAS_EN),
      .hs_fall_i  (hs_fall),
      .vline_i    (vline_d),
      .hit_o      (set_vec[g+1])
    );
  end

  // Pending update: a new event in the same cycle beats any clear of its bit.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < PEND_W; i++) begin
      if (ack && (src == SRC_W'(i))) clr_vec[i] = 1'b1;
    end
    if (we_clr) clr_vec[0] = 1'b1;
    pend_d = (pend_q & ~clr_vec) | set_vec;
  end

  // State registers.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      old_hs_q <= 1'b0;
      old_vs_q <= 1'b0;
      cnt_q    <= '0;
      vline_q  <= '0;
      delay_q  <= '0;
      pend_q   <= '0;
    end else begin
      if (tick) begin
        old_hs_q <= bus.crtc_hs;
        old_vs_q <= bus.crtc_vs;
      end
      cnt_q   <= cnt_d;
      vline_q <= vline_d;
      delay_q <= delay_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.INT      = int_req;
  assign bus.INT_SRC  = src;
  assign bus.LINE_CNT = cnt_q;
  assign bus.VLINE    = vline_q;

endmodule

// File: tb/tb_amstrad_int_gen.sv
// Bench for amstrad_int_gen: directed scenarios with randomized idle cycles,
// then a random soak, all compared against a line-level reference model.
module tb_amstrad_int_gen;
  import amstrad_pkg::*;

  localparam int LD   = 52;
  localparam int VD   = 2;
  localparam int NR   = 3;
  localparam int HALF = 32;
  localparam int VMAX = 511;

  logic CLK = 1'b0;
  logic rst_n;

  amstrad_int_gen_if #(.CNT_W(6), .LINE_W(9)) bus ();

  amstrad_int_gen #(
    .LINE_DIV(52), .VS_DELAY(2), .CNT_W(6), .NUM_RASTER(3), .LINE_W(9)
  ) dut (
    .CLK(CLK), .RESET_n(rst_n), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  bit m_old_hs, m_old_vs;
  int m_cnt, m_vline, m_delay, m_pend;
  int m_line [NR];
  bit m_en   [NR];
  bit vs_cur;

  task automatic model_reset();
    m_old_hs = 0; m_old_vs = 0;
    m_cnt = 0; m_vline = 0; m_delay = 0; m_pend = 0;
    for (int i = 0; i < NR; i++) begin m_line[i] = 0; m_en[i] = 0; end
  endtask

  function automatic int m_src();
    for (int i = 0; i <= NR; i++) if (m_pend[i]) return i;
    return 0;
  endfunction

  // One clock of the behavioural model, using the inputs applied this cycle.
  task automatic model_step();
    bit tick, hf, vr, resync, wclr, ackv;
    int src, raised, clear, ncnt;
    if (!rst_n) begin model_reset(); return; end
    tick = bus.CE_4 && bus.SAMPLE;
    hf = tick && m_old_hs && !bus.crtc_hs;
    vr = tick && !m_old_vs && bus.crtc_vs;
    if (tick) begin m_old_hs = bus.crtc_hs; m_old_vs = bus.crtc_vs; end
    src  = m_src();
    ackv = bus.INTack && (m_pend != 0);
    wclr = bus.WE && (bus.D[7:6] == 2'b10) && bus.D[4];
    raised = 0;
    resync = 0;
    if (vr) m_delay = VD;
    else if (hf && m_delay > 0) begin m_delay--; resync = (m_delay == 0); end
    ncnt = m_cnt;
    if (wclr) ncnt = 0;
    else if (resync) begin ncnt = 0; if (m_cnt >= HALF) raised |= 1; end
    else if (hf) begin
      if (m_cnt == LD - 1) begin ncnt = 0; raised |= 1; end
      else ncnt = m_cnt + 1;
    end
    if (ackv && src == 0) ncnt = ncnt % HALF;
    m_cnt = ncnt;
    if (vr) m_vline = 0;
    else if (hf && m_vline < VMAX) m_vline++;
    for (int c = 0; c < NR; c++)
      if (hf && m_en[c] && m_line[c] == m_vline) raised |= (1 << (c + 1));
    if (bus.RAS_WE && bus.RAS_SEL < NR) begin
      m_line[bus.RAS_SEL] = int'(bus.RAS_LINE);
      m_en[bus.RAS_SEL]   = bus.RAS_EN;
    end
    clear = (ackv ? (1 << src) : 0) | (wclr ? 1 : 0);
    m_pend = (m_pend & ~clear) | raised;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":INT"},      32'(bus.INT),      32'(m_pend != 0));
    chk({tag, ":INT_SRC"},  32'(bus.INT_SRC),  32'(m_src()));
    chk({tag, ":LINE_CNT"}, 32'(bus.LINE_CNT), 32'(m_cnt));
    chk({tag, ":VLINE"},    32'(bus.VLINE),    32'(m_vline));
  endtask

  task automatic clk_cycle();
    @(posedge CLK);
    model_step();
    #1;
    bus.INTack = 1'b0; bus.WE = 1'b0; bus.RAS_WE = 1'b0;
    bus.CE_4 = 1'b0; bus.SAMPLE = 1'b0;
  endtask

  // One sampling tick, followed by a few cycles where the strobe is suppressed.
  task automatic tick_step(input logic hs, input logic vs);
    bus.CE_4 = 1'b1; bus.SAMPLE = 1'b1;
    bus.crtc_hs = hs; bus.crtc_vs = vs;
    clk_cycle();
    check_all("tick");
    repeat ($urandom_range(0, 2)) begin
      bus.CE_4    = ($urandom_range(0, 1) == 1);
      bus.SAMPLE  = !bus.CE_4;
      bus.crtc_hs = ($urandom_range(0, 1) == 1);
      clk_cycle();
    end
  endtask

  task automatic hs_line();
    tick_step(1'b1, vs_cur);
    tick_step(1'b0, vs_cur);
  endtask

  task automatic ack_cycle(input string tag);
    bus.INTack = 1'b1;
    clk_cycle();
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.CE_4 = 0; bus.SAMPLE = 0; bus.crtc_hs = 0; bus.crtc_vs = 0;
    bus.INTack = 0; bus.WE = 0; bus.D = 8'h00;
    bus.RAS_WE = 0; bus.RAS_SEL = 3'd0; bus.RAS_LINE = 9'd0; bus.RAS_EN = 0;
    vs_cur = 0;
    model_reset();
    repeat (3) clk_cycle();
    check_all("reset");
    chk("reset_int", 32'(bus.INT), 32'd0);
    #2 rst_n = 1'b1;

    // Free-running HSYNC: interrupt on the 52nd fall.
    repeat (LD - 1) hs_line();
    chk("t1_before", 32'(bus.INT), 32'd0);
    hs_line();
    chk("t1_int", 32'(bus.INT), 32'd1);
    chk("t1_src", 32'(bus.INT_SRC), 32'd0);
    chk("t1_cnt", 32'(bus.LINE_CNT), 32'd0);
    ack_cycle("t1_ack");
    chk("t1_ack_int", 32'(bus.INT), 32'd0);

    // VSYNC at count 40 resyncs with interrupt; at count 20 without.
    repeat (40) hs_line();
    vs_cur = 1; tick_step(1'b0, vs_cur);
    hs_line();
    chk("t2a_l1", 32'(bus.INT), 32'd0);
    hs_line();
    chk("t2a_int", 32'(bus.INT), 32'd1);
    chk("t2a_cnt", 32'(bus.LINE_CNT), 32'd0);
    ack_cycle("t2a_ack");
    vs_cur = 0; tick_step(1'b0, vs_cur);
    repeat (20) hs_line();
    vs_cur = 1; tick_step(1'b0, vs_cur);
    repeat (2) hs_line();
    chk("t2b_int", 32'(bus.INT), 32'd0);
    chk("t2b_cnt", 32'(bus.LINE_CNT), 32'd0);
    vs_cur = 0; tick_step(1'b0, vs_cur);

    // Late ack drops the guard bit: 35 -> 3, next interrupt 49 lines on.
    repeat (LD) hs_line();
    chk("t3_int", 32'(bus.INT), 32'd1);
    repeat (35) hs_line();
    chk("t3_cnt35", 32'(bus.LINE_CNT), 32'd35);
    ack_cycle("t3_ack");
    chk("t3_cnt3", 32'(bus.LINE_CNT), 32'd3);
    repeat (48) hs_line();
    chk("t3_48", 32'(bus.INT), 32'd0);
    hs_line();
    chk("t3_49", 32'(bus.INT), 32'd1);
    ack_cycle("t3_ack2");

    // Raster channel 1 at line 100 alongside a periodic interrupt.
    bus.RAS_WE = 1; bus.RAS_SEL = 3'd1; bus.RAS_LINE = 9'd100; bus.RAS_EN = 1;
    clk_cycle();
    bus.RAS_WE = 1; bus.RAS_SEL = 3'd5; bus.RAS_LINE = 9'd7; bus.RAS_EN = 1;
    clk_cycle();
    vs_cur = 1; tick_step(1'b0, vs_cur);
    repeat (99) hs_line();
    chk("t4_99_src", 32'(bus.INT_SRC), 32'd0);
    hs_line();
    chk("t4_vline", 32'(bus.VLINE), 32'd100);
    chk("t4_src0", 32'(bus.INT_SRC), 32'd0);
    ack_cycle("t4_ack1");
    chk("t4_src2", 32'(bus.INT_SRC), 32'd2);
    ack_cycle("t4_ack2");
    chk("t4_int0", 32'(bus.INT), 32'd0);
    vs_cur = 0; tick_step(1'b0, vs_cur);

    // Register clear in the same cycle as the wrap.
    for (int k = 0; k < 60 && m_cnt != LD - 1; k++) hs_line();
    chk("t5_pre", 32'(bus.LINE_CNT), 32'd51);
    tick_step(1'b1, vs_cur);
    bus.WE = 1; bus.D = 8'h90;
    tick_step(1'b0, vs_cur);
    chk("t5_cnt", 32'(bus.LINE_CNT), 32'd0);
    chk("t5_int", 32'(bus.INT), 32'd0);
    repeat (10) hs_line();
    bus.WE = 1; bus.D = 8'h80; clk_cycle(); check_all("t5_80");
    bus.WE = 1; bus.D = 8'hD0; clk_cycle(); check_all("t5_D0");
    chk("t5_keep", 32'(bus.LINE_CNT), 32'd10);
    bus.WE = 1; bus.D = 8'h90; clk_cycle(); check_all("t5_90");

    // Asynchronous reset mid-frame.
    repeat (30) hs_line();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("t6_rst");
    chk("t6_cnt", 32'(bus.LINE_CNT), 32'd0);
    repeat (2) clk_cycle();
    #2 rst_n = 1'b1;
    ack_cycle("t6_ack_idle");
    chk("t6_ack_cnt", 32'(bus.LINE_CNT), 32'd0);
    repeat (LD - 1) hs_line();
    chk("t6_51", 32'(bus.INT), 32'd0);
    hs_line();
    chk("t6_52", 32'(bus.INT), 32'd1);
    ack_cycle("t6_ack");

    // Scanline counter saturates.
    repeat (VMAX + 4) hs_line();
    chk("sat_vline", 32'(bus.VLINE), 32'd511);

    // Random soak.
    for (int n = 0; n < 3000; n++) begin
      bus.CE_4    = ($urandom_range(0, 1) == 1);
      bus.SAMPLE  = ($urandom_range(0, 1) == 1);
      bus.crtc_hs = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 39) == 0) vs_cur = !vs_cur;
      bus.crtc_vs = vs_cur;
      bus.INTack  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.WE = 1;
        bus.D  = ($urandom_range(0, 1) == 1) ? 8'h90 : 8'($urandom);
      end
      if ($urandom_range(0, 29) == 0) begin
        bus.RAS_WE   = 1;
        bus.RAS_SEL  = 3'($urandom_range(0, 7));
        bus.RAS_LINE = 9'($urandom_range(0, 12));
        bus.RAS_EN   = ($urandom_range(0, 1) == 1);
      end
      clk_cycle();
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
